// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake, shift-add multiplier and persistent PSR.
// Latency: single-cycle ops return done one cycle after the accepting edge; MUL after WIDTH+1 edges.
// Backpressure: start is only honoured while busy=0; a start during a multiply is dropped, never queued.
module alu_seq #(
    // Operand/result width; must be even and at least 4.
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       operationControl,
    input  logic [WIDTH-1:0] sourceData,
    input  logic [WIDTH-1:0] destData,
    input  logic             flagsLoad,
    input  logic [4:0]       flagsIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             low,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // Primary opcodes (operationControl[7:4])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // R-type extensions (operationControl[3:0] when opcode is RTYPE)
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_SUBC = 4'b1010;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_MUL  = 4'b1110;

    // Shift extensions (operationControl[3:0] when opcode is SHIFT)
    localparam logic [3:0] SH_LSHIPOS  = 4'b0000;
    localparam logic [3:0] SH_LSHINEG  = 4'b0001;
    localparam logic [3:0] SH_ASHUIPOS = 4'b0010;
    localparam logic [3:0] SH_ASHUINEG = 4'b0011;
    localparam logic [3:0] SH_LSH      = 4'b0100;
    localparam logic [3:0] SH_ASHU     = 4'b0110;

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);

    // Internal operation classes; immediate and R-forms collapse onto the same class.
    typedef enum logic [4:0] {
        K_ILL, K_AND, K_OR, K_XOR, K_ADD, K_ADDU, K_ADDC, K_SUB, K_SUBC,
        K_CMP, K_MOV, K_MUL, K_LUI, K_SHL1, K_SHR1, K_ASR1, K_LSH, K_ASHU
    } kind_t;

    typedef enum logic [1:0] {IDLE, EXEC, MULT} state_t;

    state_t             state;
    kind_t              kind;
    logic [3:0]         op;
    logic [3:0]         ext;
    logic               cin_sel;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               add_ovf;
    logic               sub_ovf;
    logic [WIDTH-1:0]   alu_res;
    logic               wr_res;
    logic               upd_c, upd_l, upd_f, upd_z, upd_n;
    logic               nxt_c, nxt_l, nxt_f, nxt_z, nxt_n;
    logic               accept;
    logic [WIDTH-1:0]   mul_acc;
    logic [WIDTH-1:0]   mul_mcand;
    logic [WIDTH-1:0]   mul_mplier;
    logic [WIDTH-1:0]   mul_addend;
    logic [CNT_W-1:0]   mul_cnt;

    // Shift by a signed amount: non-negative goes left, negative goes right by the magnitude.
    // Out-of-range magnitudes flush to zero, except an arithmetic right shift which fills with sign.
    function automatic logic [WIDTH-1:0] shift_signed(input logic [WIDTH-1:0] val,
                                                      input logic [WIDTH-1:0] amt,
                                                      input logic             arith);
        logic [WIDTH-1:0] mag;
        logic [WIDTH-1:0] res;
        mag = amt[WIDTH-1] ? (~amt + WIDTH'(1)) : amt;
        if (mag >= W_VAL) begin
            res = (arith && amt[WIDTH-1]) ? {WIDTH{val[WIDTH-1]}} : '0;
        end else if (amt[WIDTH-1]) begin
            res = arith ? $unsigned($signed(val) >>> mag) : (val >> mag);
        end else begin
            res = val << mag;
        end
        return res;
    endfunction

    assign op     = operationControl[7:4];
    assign ext    = operationControl[3:0];
    assign accept = start && !busy;

    // Carry-in comes from the stored PSR, so a preceding op's carry is already visible here.
    assign cin_sel  = carry && (kind == K_ADDC || kind == K_SUBC);
    assign add_sum  = {1'b0, destData} + {1'b0, sourceData} + {{WIDTH{1'b0}}, cin_sel};
    assign sub_diff = {1'b0, destData} - {1'b0, sourceData} - {{WIDTH{1'b0}}, cin_sel};
    assign add_ovf  = (destData[WIDTH-1] == sourceData[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != destData[WIDTH-1]);
    assign sub_ovf  = (destData[WIDTH-1] != sourceData[WIDTH-1]) &&
                      (sub_diff[WIDTH-1] != destData[WIDTH-1]);

    assign mul_addend = mul_mplier[0] ? mul_mcand : '0;

    // Decode the 8-bit control word into an operation class.
    always_comb begin
        kind = K_ILL;
        case (op)
            OP_RTYPE: begin
                case (ext)
                    EXT_AND:  kind = K_AND;
                    EXT_OR:   kind = K_OR;
                    EXT_XOR:  kind = K_XOR;
                    EXT_ADD:  kind = K_ADD;
                    EXT_ADDU: kind = K_ADDU;
                    EXT_ADDC: kind = K_ADDC;
                    EXT_SUB:  kind = K_SUB;
                    EXT_SUBC: kind = K_SUBC;
                    EXT_CMP:  kind = K_CMP;
                    EXT_MOV:  kind = K_MOV;
                    EXT_MUL:  kind = K_MUL;
                    default:  kind = K_ILL;
                endcase
            end
            OP_ANDI:  kind = K_AND;
            OP_ORI:   kind = K_OR;
            OP_XORI:  kind = K_XOR;
            OP_ADDI:  kind = K_ADD;
            OP_ADDUI: kind = K_ADDU;
            OP_SUBI:  kind = K_SUB;
            OP_CMPI:  kind = K_CMP;
            OP_MOVI:  kind = K_MOV;
            OP_LUI:   kind = K_LUI;
            OP_SHIFT: begin
                case (ext)
                    SH_LSHIPOS:  kind = K_SHL1;
                    SH_LSHINEG:  kind = K_SHR1;
                    SH_ASHUIPOS: kind = K_SHL1;   // arithmetic left is identical to logical left
                    SH_ASHUINEG: kind = K_ASR1;
                    SH_LSH:      kind = K_LSH;
                    SH_ASHU:     kind = K_ASHU;
                    default:     kind = K_ILL;
                endcase
            end
            default: kind = K_ILL;
        endcase
    end

    // Compute the single-cycle result and which PSR bits the op writes.
    always_comb begin
        alu_res = '0;
        wr_res  = 1'b1;
        upd_c   = 1'b0;
        upd_l   = 1'b0;
        upd_f   = 1'b0;
        upd_z   = 1'b0;
        upd_n   = 1'b0;
        nxt_c   = 1'b0;
        nxt_l   = 1'b0;
        nxt_f   = 1'b0;
        nxt_z   = 1'b0;
        nxt_n   = 1'b0;
        case (kind)
            K_AND:  alu_res = destData & sourceData;
            K_OR:   alu_res = destData | sourceData;
            K_XOR:  alu_res = destData ^ sourceData;
            K_ADD, K_ADDC: begin
                alu_res = add_sum[WIDTH-1:0];
                upd_c   = 1'b1;
                nxt_c   = add_sum[WIDTH];
                upd_f   = 1'b1;
                nxt_f   = add_ovf;
            end
            K_ADDU: begin
                alu_res = add_sum[WIDTH-1:0];
                upd_c   = 1'b1;
                nxt_c   = add_sum[WIDTH];
            end
            K_SUB, K_SUBC: begin
                alu_res = sub_diff[WIDTH-1:0];
                upd_c   = 1'b1;
                nxt_c   = sub_diff[WIDTH];      // borrow out of the extended subtraction
                upd_f   = 1'b1;
                nxt_f   = sub_ovf;
            end
            K_CMP: begin
                wr_res = 1'b0;
                upd_l  = 1'b1;
                nxt_l  = sourceData > destData;
                upd_n  = 1'b1;
                nxt_n  = $signed(destData) < $signed(sourceData);
                upd_z  = 1'b1;
                nxt_z  = sourceData == destData;
            end
            K_MOV:  alu_res = sourceData;
            K_LUI:  alu_res = {sourceData[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            K_SHL1: alu_res = {destData[WIDTH-2:0], 1'b0};
            K_SHR1: alu_res = {1'b0, destData[WIDTH-1:1]};
            K_ASR1: alu_res = {destData[WIDTH-1], destData[WIDTH-1:1]};
            K_LSH:  alu_res = shift_signed(destData, sourceData, 1'b0);
            K_ASHU: alu_res = shift_signed(destData, sourceData, 1'b1);
            default: alu_res = '0;              // illegal encodings (and MUL, handled by the FSM)
        endcase
    end

    // Control FSM, multiplier datapath and PSR; flagsIn overrides any same-edge op flag update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            carry      <= 1'b0;
            low        <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            negative   <= 1'b0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, EXEC: begin
                    if (accept && kind == K_MUL) begin
                        mul_acc    <= '0;
                        mul_mcand  <= destData;
                        mul_mplier <= sourceData;
                        mul_cnt    <= '0;
                        busy       <= 1'b1;
                        state      <= MULT;
                    end else if (accept) begin
                        if (wr_res) result <= alu_res;
                        if (upd_c) carry    <= nxt_c;
                        if (upd_l) low      <= nxt_l;
                        if (upd_f) overflow <= nxt_f;
                        if (upd_z) zero     <= nxt_z;
                        if (upd_n) negative <= nxt_n;
                        done  <= 1'b1;
                        state <= EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                MULT: begin
                    // One shift-add step per cycle; the last step writes straight to result.
                    mul_acc    <= mul_acc + mul_addend;
                    mul_mcand  <= {mul_mcand[WIDTH-2:0], 1'b0};
                    mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
                    mul_cnt    <= mul_cnt + CNT_W'(1);
                    if (mul_cnt == MUL_LAST) begin
                        result <= mul_acc + mul_addend;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (flagsLoad) begin
                {carry, low, overflow, zero, negative} <= flagsIn;
            end
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the datapath ALU. It executes the same 8-bit `operationControl` encoding (opcode `[7:4]`, extension `[3:0]`) on `WIDTH`-bit operands, with four additions:
- a start/done handshake;
- an iterative shift-add multiplier;
- a persistent flag register (PSR), so `ADDC`/`SUBC` consume a real stored carry;
- a PSR load port for the controller (context restore).

It sits between the register file and the writeback mux, under control of the instruction controller.

## Interface
- `WIDTH`, 16: operand/result width; must be even and ≥ 4.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: accept `operationControl`/operands this cycle when `busy`=0.
- `operationControl` input 8: opcode `[7:4]`, extension `[3:0]`.
- `sourceData` input WIDTH: operand A; carries the immediate for I-forms.
- `destData` input WIDTH: operand B.
- `flagsLoad` input 1: load PSR from `flagsIn`.
- `flagsIn` input 5: `{carry, low, overflow, zero, negative}`.
- `busy` output 1: multiply in progress.
- `done` output 1: one-cycle pulse; `result`/flags valid.
- `result` output WIDTH: registered result, held until the next `done`.
- `carry`, `low`, `overflow`, `zero`, `negative` output 1 each: registered PSR bits.

## Operation
- **Opcodes.** `RTYPE` 0000 selects on the extension: `AND` 0001, `OR` 0010, `XOR` 0011, `ADD` 0101, `ADDU` 0110, `ADDC` 0111, `SUB` 1001, `SUBC` 1010, `CMP` 1011, `MOV` 1101, `MUL` 1110.
- **Immediate forms.** Selected directly by opcode, same semantics as the R-form: `ANDI` 0001, `ORI` 0010, `XORI` 0011, `ADDI` 0101, `ADDUI` 0110, `SUBI` 1001, `CMPI` 1011, `MOVI` 1101, `LUI` 1111.
- **Shift opcode 1000**, by extension:
  - `LSHIPOS` 0000: `destData` << 1.
  - `LSHINEG` 0001: `destData` >> 1, logical.
  - `ASHUIPOS` 0010: arithmetic shift left by 1.
  - `ASHUINEG` 0011: arithmetic shift right by 1.
  - `LSH` 0100: logical shift by signed `sourceData`.
  - `ASHU` 0110: arithmetic shift by signed `sourceData`.
- **Signed shift amounts.** Non-negative shifts left, negative shifts right by the magnitude. Magnitude ≥ `WIDTH` gives 0, except an `ASHU` right shift, which gives all sign bits.
- **Arithmetic.**
  - `ADD`-family: `dest + src (+ C for ADDC)`.
  - `SUB`-family: `dest − src (− C for SUBC)`.
  - `MOV`/`MOVI`: `result = sourceData`.
  - `LUI`: `result = {sourceData[WIDTH/2−1:0], WIDTH/2 zeros}`.
  - `MUL`: low `WIDTH` bits of the unsigned product. Two's-complement operands therefore give the correct low bits.
- **Flag updates.** Flags not listed for an op keep their value.
  - `ADD`, `ADDI`, `ADDC`: C = carry out; F (`overflow`) = signed overflow.
  - `ADDU`, `ADDUI`: C only.
  - `SUB`, `SUBI`, `SUBC`: C = unsigned borrow (`src` (+C) > `dest`); F = signed overflow of `dest − src`.
  - `CMP`, `CMPI`: L = `src` > `dest` unsigned; N = `dest` < `src` signed; Z = `src` == `dest`. `result` is unchanged.
  - Logic, move, shift, `LUI`, `MUL`: no flags.
- **Illegal encodings.** `result` = 0, flags unchanged, `done` still pulses.
- **State machine: IDLE → EXEC → IDLE** (single-cycle ops).
  - In IDLE with `start`=1: operands are computed and registered at that edge.
  - `done`=1 during the next cycle.
- **State machine: IDLE → MULT → IDLE** (`MUL`).
  - Operands are latched on the `start` edge and `busy` rises.
  - The multiplier performs one shift-add per cycle for `WIDTH` cycles.
  - On the final iteration edge `result` is written, `busy` falls and `done` pulses.
- **`start` while `busy`=1** is ignored; no queueing.
- **Operand stability.** Operands are only sampled at the accepting edge and may change afterwards.
- **`flagsLoad`.** Writes the PSR at the edge; allowed in any state. If it coincides with an op's flag update, `flagsIn` wins. The op's `result` and `done` are unaffected.

## Timing
- **Reset:** state IDLE; `busy`, `done`, `result`, all flags = 0.
  - Asynchronous; a reset during MULT aborts it with no `done`.
- **Single-cycle op:** `start` at edge n, `result`/flags/`done` visible after edge n+1.
  - Back-to-back `start` every cycle is sustained.
- **`MUL`:** `start` at edge n, `busy`=1 after edge n+1, `result` and `done` after edge n+`WIDTH`+1 (`busy`=0 in the same cycle).
  - A new `start` is accepted in that `done` cycle.
- **`ADDC`/`SUBC` carry:** they use the PSR carry as registered before their accepting edge. This includes the carry produced by the immediately preceding op.

## Test plan
- **Signed overflow:** `ADD` `src`=0x0001, `dest`=0x7FFF → `result`=0x8000, F=1, C=0, `done` exactly one cycle after `start`.
- **Carry chain:** `ADD` 0xFFFF+0x0001 → 0x0000, C=1; next cycle `ADDC` 0x0001+0x0001 → 0x0003, C=0.
- **Multiply timing:** `MUL` 0x0123×0x0010 → 0x1230.
  - `busy` high for 16 cycles, `done` on the 17th after `start`.
  - A `start` (`ADD`) issued mid-busy is ignored; `result` stays 0x1230.
- **Compare:** `CMP` `src`=0xFFFF, `dest`=0x0001 → L=1, N=0, Z=0, `result` unchanged.
  - `CMP` 0x0005 vs `dest` 0x0005 → Z=1, L=0, N=0.
- **Arithmetic shift:** `ASHU` `src`=0xFFFC, `dest`=0x8010 → 0xF801; `src`=0x0014 → 0x0000; `src`=0xFFEC, `dest`=0x8000 → 0xFFFF.
- **Reset and PSR load:** reset asserted 5 cycles into `MUL` → `busy`=0, `done` never pulses, `result`=0, flags=0.
  - `flagsLoad` with `flagsIn`=0b10101 coincident with an `ADD` producing C=0 → PSR = 0b10101.
